// File: rtl/axi_master_generic_if.sv
// rtl/axi_master_generic_if.sv - AXI3 five-channel bundle between master engine and slave
// Purpose: groups the AW, W, B, AR and R channel signals of one 32-bit AXI3 link.
// Signals:
//   AW: awid[3:0] awadr[31:0] awlen[3:0] awsize[2:0] awburst[1:0] awlock[1:0]
//       awcache[3:0] awprot[2:0] awvalid / awready
//   W : wid[3:0] wrdata[31:0] wstrb[3:0] wlast wvalid / wready
//   B : bid[3:0] bresp[1:0] bvalid / bready
//   AR: arid[3:0] araddr[31:0] arlen[3:0] arsize[2:0] arlock[1:0] arcache[3:0]
//       arprot[2:0] arvalid / arready
//   R : rid[3:0] rdata[31:0] rresp[1:0] rlast rvalid / rready
// Modports: master (drives AW/W/AR and the B/R readies), slave (the reverse).
interface axi_master_generic_if;
  logic [3:0]  awid;
  logic [31:0] awadr;
  logic [3:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wrdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    input  awready,
    output wid, wrdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arlock, arcache, arprot, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

  modport slave (
    input  awid, awadr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
    output awready,
    input  wid, wrdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arlock, arcache, arprot, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );
endinterface

// File: rtl/axi_master_generic.sv
// rtl/axi_master_generic.sv - single-outstanding AXI3 INCR burst master engine
// Purpose: turns one command (addr, len, dir, id) into an AXI3 INCR burst of 32-bit beats,
//   streaming write beats from the user write port and returning read beats on the read port.
// Ports:
//   aclk, aresetn                  clock, synchronous active-low reset
//   cmd_valid/cmd_ready            command handshake (ready only when idle)
//   cmd_write/addr/len/id          command fields (len = beats - 1)
//   wr_data/wr_strb/wr_valid/wr_ready  user write beat
//   rd_data/rd_last/rd_valid       user read beat (no backpressure)
//   done/done_resp                 end-of-transaction pulse and final response
//   bus                            AXI3 master modport
module axi_master_generic #(
  parameter int TIMEOUT = 256,
  parameter int TO_W    = 9
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [31:0] cmd_addr,
  input  logic [3:0]  cmd_len,
  input  logic [3:0]  cmd_id,
  input  logic [31:0] wr_data,
  input  logic [3:0]  wr_strb,
  input  logic        wr_valid,
  output logic        wr_ready,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        rd_valid,
  output logic        done,
  output logic [1:0]  done_resp,
  axi_master_generic_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_RD_ADDR, S_RD_DATA, S_RD_DONE
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic [3:0]      len_q, len_d;
  logic [3:0]      id_q, id_d;
  logic [3:0]      beat_q, beat_d;
  logic            awvalid_q, awvalid_d;
  logic            arvalid_q, arvalid_d;
  logic [1:0]      resp_acc_q, resp_acc_d;
  logic            done_q, done_d;
  logic [1:0]      done_resp_q, done_resp_d;
  logic [31:0]     rd_data_q, rd_data_d;
  logic            rd_valid_q, rd_valid_d;
  logic            rd_last_q, rd_last_d;
  logic [TO_W-1:0] wd_q, wd_d;

  logic in_wdata, in_wresp, in_rdata;
  logic aw_hs, w_hs, b_hs, ar_hs, r_hs, progress;
  logic [7:0] unused_ids;

  assign in_wdata = (state_q == S_WR_DATA);
  assign in_wresp = (state_q == S_WR_RESP);
  assign in_rdata = (state_q == S_RD_DATA);

  assign aw_hs    = awvalid_q & bus.awready;
  assign w_hs     = in_wdata & wr_valid & bus.wready;
  assign b_hs     = in_wresp & bus.bvalid;
  assign ar_hs    = arvalid_q & bus.arready;
  assign r_hs     = in_rdata & bus.rvalid;
  assign progress = aw_hs | w_hs | b_hs | ar_hs | r_hs;

  // done is visible in the first IDLE cycle, so ready is masked to keep them exclusive.
  assign cmd_ready = (state_q == S_IDLE) & ~done_q;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    id_d        = id_q;
    beat_d      = beat_q;
    awvalid_d   = awvalid_q;
    arvalid_d   = arvalid_q;
    resp_acc_d  = resp_acc_q;
    done_d      = 1'b0;
    done_resp_d = done_resp_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = 1'b0;
    rd_last_d   = 1'b0;
    wd_d        = wd_q;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_d     = cmd_addr & 32'hFFFF_FFFC;
          len_d      = cmd_len;
          id_d       = cmd_id;
          beat_d     = 4'd0;
          resp_acc_d = 2'b00;
          if (cmd_write) begin
            state_d   = S_WR_ADDR;
            awvalid_d = 1'b1;
          end else begin
            state_d   = S_RD_ADDR;
            arvalid_d = 1'b1;
          end
        end
      end
      S_WR_ADDR: begin
        if (aw_hs) begin
          awvalid_d = 1'b0;
          state_d   = S_WR_DATA;
        end
      end
      S_WR_DATA: begin
        if (w_hs) begin
          if (beat_q == len_q) begin
            beat_d  = 4'd0;
            state_d = S_WR_RESP;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      S_WR_RESP: begin
        if (b_hs) begin
          done_resp_d = bus.bresp;
          done_d      = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        if (ar_hs) begin
          arvalid_d = 1'b0;
          state_d   = S_RD_DATA;
        end
      end
      S_RD_DATA: begin
        if (r_hs) begin
          rd_data_d  = bus.rdata;
          rd_valid_d = 1'b1;
          rd_last_d  = bus.rlast;
          if (bus.rresp > resp_acc_q) resp_acc_d = bus.rresp;
          // A slave that never asserts rlast still terminates after len+1 beats.
          if (bus.rlast || (beat_q == len_q)) begin
            beat_d  = 4'd0;
            state_d = S_RD_DONE;
          end else begin
            beat_d = beat_q + 4'd1;
          end
        end
      end
      S_RD_DONE: begin
        done_d      = 1'b1;
        done_resp_d = resp_acc_q;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Watchdog: any progress or state change restarts the count; expiry aborts the burst.
    if ((state_q == S_IDLE) || progress || (state_d != state_q)) begin
      wd_d = '0;
    end else if (wd_q == TO_W'(TIMEOUT - 1)) begin
      wd_d        = '0;
      state_d     = S_IDLE;
      awvalid_d   = 1'b0;
      arvalid_d   = 1'b0;
      beat_d      = 4'd0;
      done_d      = 1'b1;
      done_resp_d = 2'b11;
    end else begin
      wd_d = wd_q + TO_W'(1);
    end
  end

  always_ff @(posedge aclk) begin
    if (!aresetn) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      id_q        <= '0;
      beat_q      <= '0;
      awvalid_q   <= 1'b0;
      arvalid_q   <= 1'b0;
      resp_acc_q  <= '0;
      done_q      <= 1'b0;
      done_resp_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
      rd_last_q   <= 1'b0;
      wd_q        <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      id_q        <= id_d;
      beat_q      <= beat_d;
      awvalid_q   <= awvalid_d;
      arvalid_q   <= arvalid_d;
      resp_acc_q  <= resp_acc_d;
      done_q      <= done_d;
      done_resp_q <= done_resp_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
      rd_last_q   <= rd_last_d;
      wd_q        <= wd_d;
    end
  end

  assign bus.awid    = id_q;
  assign bus.awadr   = addr_q;
  assign bus.awlen   = len_q;
  assign bus.awsize  = 3'b010;
  assign bus.awburst = 2'b01;
  assign bus.awlock  = 2'b00;
  assign bus.awcache = 4'b0000;
  assign bus.awprot  = 3'b000;
  assign bus.awvalid = awvalid_q;

  // W data path is combinational from the user port, gated to zero outside WR_DATA.
  assign bus.wid     = id_q;
  assign bus.wrdata  = in_wdata ? wr_data : 32'd0;
  assign bus.wstrb   = in_wdata ? wr_strb : 4'd0;
  assign bus.wlast   = in_wdata & (beat_q == len_q);
  assign bus.wvalid  = in_wdata & wr_valid;
  assign wr_ready    = in_wdata & bus.wready;

  assign bus.bready  = in_wresp;

  assign bus.arid    = id_q;
  assign bus.araddr  = addr_q;
  assign bus.arlen   = len_q;
  assign bus.arsize  = 3'b010;
  assign bus.arlock  = 2'b00;
  assign bus.arcache = 4'b0000;
  assign bus.arprot  = 3'b000;
  assign bus.arvalid = arvalid_q;

  assign bus.rready  = in_rdata;

  assign rd_data   = rd_data_q;
  assign rd_valid  = rd_valid_q;
  assign rd_last   = rd_last_q;
  assign done      = done_q;
  assign done_resp = done_resp_q;

  // Response IDs are not checked with only one transaction in flight.
  assign unused_ids = {bus.bid, bus.rid};

endmodule

// File: tb/tb_axi_master_generic.sv
// tb/tb_axi_master_generic.sv - directed self-checking bench for axi_master_generic
module tb_axi_master_generic;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [3:0]  cmd_len = '0;
  logic [3:0]  cmd_id = '0;
  logic [31:0] wr_data = '0;
  logic [3:0]  wr_strb = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        rd_valid;
  logic        done;
  logic [1:0]  done_resp;

  int n_checks = 0;
  int n_pass   = 0;

  axi_master_generic_if bus ();

  axi_master_generic #(.TIMEOUT(256), .TO_W(9)) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_write (cmd_write),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_id    (cmd_id),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .rd_data   (rd_data),
    .rd_last   (rd_last),
    .rd_valid  (rd_valid),
    .done      (done),
    .done_resp (done_resp),
    .bus       (bus)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic issue_cmd(input logic wr, input logic [31:0] addr, input logic [3:0] len,
                           input logic [3:0] id);
    @(negedge aclk);
    cmd_write = wr; cmd_addr = addr; cmd_len = len; cmd_id = id; cmd_valid = 1'b1;
    #1 check("cmd_ready_idle", cmd_ready, 1);
    @(negedge aclk);
    cmd_valid = 1'b0;
  endtask

  task automatic run_write(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                           input logic [31:0] base, input bit toggle, input logic [1:0] bresp_v);
    int beats;
    int wcyc;
    wr_valid = 1'b1; wr_strb = 4'hF; wr_data = base;
    issue_cmd(1'b1, addr, len, id);
    check("awvalid", bus.awvalid, 1);
    check("awadr", bus.awadr, addr & 32'hFFFF_FFFC);
    check("awlen", bus.awlen, {28'd0, len});
    check("awid", bus.awid, {28'd0, id});
    check("w_before_aw", bus.wvalid, 0);
    bus.awready = 1'b1;
    @(negedge aclk);
    bus.awready = 1'b0;
    check("awvalid_drop", bus.awvalid, 0);
    beats = 0; wcyc = 0;
    for (int cyc = 0; cyc < 64 && beats <= int'(len); cyc++) begin
      wr_data = base + 32'(beats);
      bus.wready = toggle ? (wcyc % 2 == 0) : 1'b1;
      #1;
      if (bus.wvalid) begin
        check("wrdata", bus.wrdata, base + 32'(beats));
        check("wlast", bus.wlast, (beats == int'(len)) ? 1 : 0);
        check("wid", bus.wid, {28'd0, id});
        if (bus.wready) beats++;
        wcyc++;
      end
      @(negedge aclk);
    end
    bus.wready = 1'b0; wr_valid = 1'b0;
    check("beat_count", beats, int'(len) + 1);
    check("bready", bus.bready, 1);
    check("wvalid_after", bus.wvalid, 0);
    bus.bvalid = 1'b1; bus.bresp = bresp_v;
    @(negedge aclk);
    bus.bvalid = 1'b0; bus.bresp = 2'b00;
    check("wr_done", done, 1);
    check("wr_done_resp", done_resp, {30'd0, bresp_v});
    check("wr_done_excl", cmd_ready, 0);
    @(negedge aclk);
    check("wr_done_pulse", done, 0);
    check("wr_idle_ready", cmd_ready, 1);
  endtask

  task automatic run_read(input logic [31:0] addr, input logic [3:0] len, input logic [3:0] id,
                          input int last_at, input bit give_rlast, input int bad_beat,
                          input logic [1:0] bad_resp, input logic [1:0] exp_resp, input bit poke);
    issue_cmd(1'b0, addr, len, id);
    check("arvalid", bus.arvalid, 1);
    check("araddr", bus.araddr, addr & 32'hFFFF_FFFC);
    check("arlen", bus.arlen, {28'd0, len});
    check("arid", bus.arid, {28'd0, id});
    check("arsize", bus.arsize, 3'b010);
    bus.arready = 1'b1;
    @(negedge aclk);
    bus.arready = 1'b0;
    check("arvalid_drop", bus.arvalid, 0);
    check("rready", bus.rready, 1);
    for (int b = 0; b <= last_at; b++) begin
      bus.rvalid = 1'b1;
      bus.rdata  = 32'hA + 32'(b);
      bus.rresp  = (b == bad_beat) ? bad_resp : 2'b00;
      bus.rlast  = give_rlast && (b == last_at);
      if (poke) begin
        cmd_valid = 1'b1; cmd_write = 1'b1;
        #1 check("busy_cmd_ready", cmd_ready, 0);
      end
      @(negedge aclk);
      bus.rvalid = 1'b0; bus.rlast = 1'b0; bus.rresp = 2'b00; cmd_valid = 1'b0;
      check("rd_valid", rd_valid, 1);
      check("rd_data", rd_data, 32'hA + 32'(b));
      check("rd_last", rd_last, (give_rlast && b == last_at) ? 1 : 0);
    end
    check("rd_done_early", done, 0);
    @(negedge aclk);
    check("rd_done", done, 1);
    check("rd_done_resp", done_resp, {30'd0, exp_resp});
    check("rd_done_excl", cmd_ready, 0);
    check("rd_valid_end", rd_valid, 0);
    @(negedge aclk);
    check("rd_idle_ready", cmd_ready, 1);
    check("rd_no_aw", bus.awvalid, 0);
    check("rd_no_ar", bus.arvalid, 0);
  endtask

  initial begin
    int hi_cnt;
    bus.awready = 1'b0; bus.wready = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00; bus.bid = 4'd0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = '0; bus.rresp = 2'b00; bus.rlast = 1'b0;
    bus.rid = 4'd0;

    repeat (3) @(negedge aclk);
    check("rst_awvalid", bus.awvalid, 0);
    check("rst_arvalid", bus.arvalid, 0);
    check("rst_done", done, 0);
    check("rst_done_resp", done_resp, 0);
    check("rst_awadr", bus.awadr, 0);
    check("rst_awsize", bus.awsize, 3'b010);
    check("rst_awburst", bus.awburst, 2'b01);
    aresetn = 1'b1;
    @(negedge aclk);
    check("rst_cmd_ready", cmd_ready, 1);

    // Stray responses while idle must be ignored.
    bus.rvalid = 1'b1; bus.bvalid = 1'b1; bus.bresp = 2'b10;
    @(negedge aclk);
    bus.rvalid = 1'b0; bus.bvalid = 1'b0; bus.bresp = 2'b00;
    check("idle_rd_valid", rd_valid, 0);
    check("idle_done", done, 0);

    run_write(32'h10, 4'd0, 4'd5, 32'hDEADBEEF, 1'b0, 2'b00);
    run_write(32'h200, 4'd3, 4'd9, 32'hC0DE0000, 1'b1, 2'b01);
    run_read(32'h20, 4'd3, 4'd2, 3, 1'b1, -1, 2'b00, 2'b00, 1'b0);
    run_read(32'h23, 4'd3, 4'd6, 3, 1'b1, 1, 2'b10, 2'b10, 1'b1);
    run_read(32'h40, 4'd1, 4'd1, 1, 1'b0, 0, 2'b01, 2'b01, 1'b0);
    run_read(32'h44, 4'd3, 4'd1, 1, 1'b1, -1, 2'b00, 2'b00, 1'b0);

    // awready stuck low: watchdog aborts after 256 cycles of awvalid.
    issue_cmd(1'b1, 32'h80, 4'd1, 4'd4);
    hi_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      if (done) break;
      if (bus.awvalid) hi_cnt++;
      @(negedge aclk);
    end
    check("to_awvalid_cycles", hi_cnt, 256);
    check("to_done", done, 1);
    check("to_done_resp", done_resp, 2'b11);
    check("to_awvalid", bus.awvalid, 0);
    @(negedge aclk);
    check("to_idle", cmd_ready, 1);

    // Reset during beat 2 of a len=7 write.
    wr_valid = 1'b1; wr_strb = 4'hF; wr_data = 32'h55;
    issue_cmd(1'b1, 32'h100, 4'd7, 4'd3);
    bus.awready = 1'b1;
    @(negedge aclk);
    bus.awready = 1'b0; bus.wready = 1'b1;
    @(negedge aclk);
    @(negedge aclk);
    check("mid_wvalid", bus.wvalid, 1);
    aresetn = 1'b0;
    @(negedge aclk);
    check("mid_rst_wvalid", bus.wvalid, 0);
    check("mid_rst_awvalid", bus.awvalid, 0);
    check("mid_rst_bready", bus.bready, 0);
    check("mid_rst_done_resp", done_resp, 0);
    aresetn = 1'b1; bus.wready = 1'b0; wr_valid = 1'b0;
    @(negedge aclk);
    check("mid_rst_cmd_ready", cmd_ready, 1);

    run_write(32'h33, 4'd1, 4'd7, 32'h12340000, 1'b0, 2'b10);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
